// File: rtl/iter_shift_ext_unit_pkg.sv
// Shared encodings for the iterative shift-and-extend unit: shift modes
// (also decoded by the control FSM) and the unit's own FSM states.
package iter_shift_ext_unit_pkg;

  typedef enum logic [1:0] {
    SHM_LOGICAL  = 2'b00,
    SHM_ARITH    = 2'b01,
    SHM_ROTATE   = 2'b10,
    SHM_RESERVED = 2'b11
  } shiftMode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shiftState_e;

endpackage

// File: rtl/iter_shift_ext_unit_shift_step.sv
// Combinational single-step shifter: moves the word by s (0..STEP) bits in
// the selected mode and direction. Reserved mode behaves as logical.
module shift_step
  import iter_shift_ext_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 4
) (
  input  logic [WIDTH-1:0]           in,
  input  logic [$clog2(STEP+1)-1:0]  s,
  input  shiftMode_e                 mode,
  input  logic                       dir,
  output logic [WIDTH-1:0]           out
);

  localparam int AW = $clog2(WIDTH) + 1;

  logic [AW-1:0] sAmt;
  logic [AW-1:0] sInv;

  assign sAmt = AW'(s);
  assign sInv = AW'(WIDTH) - sAmt;

  // Shift by s with mode-specific fill; a zero step returns the input because the wrap term shifts out fully
  always_comb begin
    out = in;
    case (mode)
      SHM_ARITH:  out = dir ? $unsigned($signed(in) >>> sAmt) : (in << sAmt);
      SHM_ROTATE: out = dir ? ((in >> sAmt) | (in << sInv)) : ((in << sAmt) | (in >> sInv));
      default:    out = dir ? (in >> sAmt) : (in << sAmt);
    endcase
  end

endmodule

// File: rtl/iter_shift_ext_unit.sv
// Multi-cycle shift-and-extend unit. Captures an operand and immediate on
// start, publishes zero/sign-extended immediates, then shifts the operand by
// the immediate at up to STEP bits per cycle and pulses done at the end.
module iter_shift_ext_unit
  import iter_shift_ext_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IMM_W = 12,
  parameter int STEP  = 4
) (
  input  logic             CLK,
  input  logic             CtrlRst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] IROut,
  input  logic [WIDTH-1:0] ShifterIn,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ShifterOut,
  output logic [WIDTH-1:0] ZeroExtOut,
  output logic [WIDTH-1:0] SignExtOut
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = $clog2(STEP + 1);
  localparam int LW = $clog2(WIDTH);

  shiftState_e      state;
  logic [CW-1:0]    rem;
  shiftMode_e       opMode;
  logic             opDir;

  logic [IMM_W-1:0] imm;
  logic [WIDTH-1:0] amtFull;
  logic [WIDTH-1:0] signExt;
  logic [CW-1:0]    effAmt;
  logic [SW-1:0]    stepAmt;
  logic [WIDTH-1:0] stepOut;
  logic             unusedIrBits;

  assign imm          = IROut[IMM_W-1:0];
  assign amtFull      = {{(WIDTH-IMM_W){1'b0}}, imm};
  assign signExt      = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
  assign unusedIrBits = ^IROut[WIDTH-1:IMM_W];

  // Effective distance: rotate wraps modulo WIDTH, every other mode saturates at WIDTH
  always_comb begin
    effAmt = '0;
    if (shiftMode_e'(mode) == SHM_ROTATE) begin
      effAmt = CW'(amtFull[LW-1:0]);
    end else if (amtFull >= WIDTH'(WIDTH)) begin
      effAmt = CW'(WIDTH);
    end else begin
      effAmt = CW'(amtFull);
    end
  end

  // This cycle's step is the remaining distance capped at STEP
  always_comb begin
    stepAmt = '0;
    if (rem > CW'(STEP)) begin
      stepAmt = SW'(STEP);
    end else begin
      stepAmt = SW'(rem);
    end
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) stepUnit (
    .in   (ShifterOut),
    .s    (stepAmt),
    .mode (opMode),
    .dir  (opDir),
    .out  (stepOut)
  );

  // Control FSM with registered busy/done; ShifterOut doubles as the working register
  always_ff @(posedge CLK or negedge CtrlRst_n) begin
    if (!CtrlRst_n) begin
      state      <= IDLE;
      rem        <= '0;
      opMode     <= SHM_LOGICAL;
      opDir      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ShifterOut <= '0;
      ZeroExtOut <= '0;
      SignExtOut <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            opMode     <= shiftMode_e'(mode);
            opDir      <= dir;
            ZeroExtOut <= amtFull;
            SignExtOut <= signExt;
            ShifterOut <= ShifterIn;
            rem        <= effAmt;
            if (effAmt == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          ShifterOut <= stepOut;
          rem        <= rem - CW'(stepAmt);
          if (rem <= CW'(STEP)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_shift_ext_unit.sv
// Randomised self-checking bench for iter_shift_ext_unit against a bit-by-bit
// behavioural model of shifting, clamping and immediate extension.
module tb_iter_shift_ext_unit;

  localparam int WIDTH = 16;
  localparam int IMM_W = 12;
  localparam int STEP  = 4;

  logic             CLK;
  logic             CtrlRst_n;
  logic             start;
  logic [WIDTH-1:0] IROut;
  logic [WIDTH-1:0] ShifterIn;
  logic [1:0]       mode;
  logic             dir;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ShifterOut;
  logic [WIDTH-1:0] ZeroExtOut;
  logic [WIDTH-1:0] SignExtOut;

  int vecCount = 0;
  int errCount = 0;

  logic [WIDTH-1:0] lastResult;
  logic [WIDTH-1:0] lastZe;
  logic [WIDTH-1:0] lastSe;

  iter_shift_ext_unit #(
    .WIDTH (WIDTH),
    .IMM_W (IMM_W),
    .STEP  (STEP)
  ) dut (
    .CLK        (CLK),
    .CtrlRst_n  (CtrlRst_n),
    .start      (start),
    .IROut      (IROut),
    .ShifterIn  (ShifterIn),
    .mode       (mode),
    .dir        (dir),
    .busy       (busy),
    .done       (done),
    .ShifterOut (ShifterOut),
    .ZeroExtOut (ZeroExtOut),
    .SignExtOut (SignExtOut)
  );

  // Free-running 10-unit clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int modelImm(input logic [WIDTH-1:0] ir);
    return int'(ir) % (1 << IMM_W);
  endfunction

  function automatic int modelSignExt(input logic [WIDTH-1:0] ir);
    int v;
    v = modelImm(ir);
    if (v >= (1 << (IMM_W - 1))) v = v + (1 << WIDTH) - (1 << IMM_W);
    return v;
  endfunction

  function automatic int modelEff(input logic [WIDTH-1:0] ir, input logic [1:0] m);
    int a;
    a = modelImm(ir);
    if (m == 2'd2) return a % WIDTH;
    return (a > WIDTH) ? WIDTH : a;
  endfunction

  // Reference: apply eff one-bit shifts using plain arithmetic
  function automatic logic [WIDTH-1:0] modelShift(input logic [WIDTH-1:0] sh, input int eff,
                                                  input logic [1:0] m, input logic d);
    longint v;
    longint top;
    longint msb;
    longint lsb;
    top = longint'(1) << WIDTH;
    v = longint'(sh);
    for (int i = 0; i < eff; i++) begin
      msb = v / (top / 2);
      lsb = v % 2;
      if (d == 1'b0) begin
        v = (v * 2) % top;
        if (m == 2'd2) v = v + msb;
      end else begin
        v = v / 2;
        if (m == 2'd1 || m == 2'd2) begin
          if ((m == 2'd1 && msb == 1) || (m == 2'd2 && lsb == 1)) v = v + top / 2;
        end
      end
    end
    return WIDTH'(v);
  endfunction

  // Start one operation from IDLE/DONE and follow it to its done cycle; optionally pulse start mid-shift
  task automatic applyStimulus(input logic [WIDTH-1:0] sh, input logic [WIDTH-1:0] ir,
                               input logic [1:0] m, input logic d, input logic glitch);
    int eff;
    int n;
    logic [WIDTH-1:0] expRes;
    eff    = modelEff(ir, m);
    n      = (eff + STEP - 1) / STEP;
    expRes = modelShift(sh, eff, m, d);
    ShifterIn = sh;
    IROut     = ir;
    mode      = m;
    dir       = d;
    start     = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    checkOutput("zeroExt", ZeroExtOut, modelImm(ir));
    checkOutput("signExt", SignExtOut, modelSignExt(ir));
    for (int k = 1; k <= n + 1; k++) begin
      checkOutput("busy", busy, (k <= n) ? 1 : 0);
      checkOutput("done", done, (k == n + 1) ? 1 : 0);
      if (k == n + 1) begin
        checkOutput("result", ShifterOut, expRes);
      end else begin
        if (glitch && k == 1) begin
          start     = 1'b1;
          ShifterIn = ~sh;
          IROut     = ~ir;
          mode      = ~m;
          dir       = ~d;
        end
        @(posedge CLK); #1;
        start = 1'b0;
      end
    end
    lastResult = expRes;
    lastZe     = WIDTH'(modelImm(ir));
    lastSe     = WIDTH'(modelSignExt(ir));
  endtask

  // One cycle with start low: done drops and every result register holds
  task automatic idleCycle();
    @(posedge CLK); #1;
    checkOutput("idleDone", done, 0);
    checkOutput("idleBusy", busy, 0);
    checkOutput("holdResult", ShifterOut, lastResult);
    checkOutput("holdZeroExt", ZeroExtOut, lastZe);
    checkOutput("holdSignExt", SignExtOut, lastSe);
  endtask

  // Directed scenarios, interruptions, then randomised traffic
  initial begin
    logic [WIDTH-1:0] rSh;
    logic [WIDTH-1:0] rIr;
    CtrlRst_n = 1'b1;
    start     = 1'b0;
    IROut     = '0;
    ShifterIn = '0;
    mode      = 2'b00;
    dir       = 1'b0;

    #2 CtrlRst_n = 1'b0;
    #1;
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstResult", ShifterOut, 0);
    checkOutput("rstZeroExt", ZeroExtOut, 0);
    checkOutput("rstSignExt", SignExtOut, 0);
    @(posedge CLK); #2;
    CtrlRst_n = 1'b1;
    @(posedge CLK); #1;

    applyStimulus(16'h0001, 16'h0005, 2'b00, 1'b0, 1'b0);
    idleCycle();
    applyStimulus(16'h8000, 16'h000F, 2'b01, 1'b1, 1'b0);
    applyStimulus(16'h1234, 16'h0014, 2'b10, 1'b0, 1'b0);
    applyStimulus(16'hFFFF, 16'h0800, 2'b00, 1'b1, 1'b0);
    idleCycle();
    for (int m = 0; m < 4; m++) begin
      applyStimulus(16'hA5A5, 16'hF000, 2'(m), 1'(m), 1'b0);
    end
    applyStimulus(16'h8001, 16'h0010, 2'b01, 1'b1, 1'b0);
    applyStimulus(16'h8001, 16'h0010, 2'b11, 1'b0, 1'b0);
    idleCycle();

    applyStimulus(16'h0F0F, 16'h0009, 2'b10, 1'b1, 1'b1);
    idleCycle();

    ShifterIn = 16'h8000;
    IROut     = 16'h000F;
    mode      = 2'b01;
    dir       = 1'b1;
    start     = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    @(posedge CLK); #1;
    checkOutput("midBusy", busy, 1);
    #1 CtrlRst_n = 1'b0;
    #1;
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortDone", done, 0);
    checkOutput("abortResult", ShifterOut, 0);
    checkOutput("abortZeroExt", ZeroExtOut, 0);
    checkOutput("abortSignExt", SignExtOut, 0);
    @(posedge CLK); #2;
    CtrlRst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK); #1;
      checkOutput("noDoneAfterAbort", done, 0);
      checkOutput("noBusyAfterAbort", busy, 0);
    end
    applyStimulus(16'h00FF, 16'h0806, 2'b00, 1'b0, 1'b0);
    idleCycle();

    for (int t = 0; t < 60; t++) begin
      rSh = WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) rIr = WIDTH'($urandom);
      else rIr = WIDTH'(($urandom & 32'h0000_F000) | $urandom_range(0, 40));
      applyStimulus(rSh, rIr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
      if ($urandom_range(0, 1) == 1) idleCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/iter_shift_ext_unit.md
# iter_shift_ext_unit

Parametrised multi-cycle shift-and-extend unit for the execute stage. Captures the operand and the instruction immediate on a start strobe, then zero- and sign-extends the immediate. It shifts the operand by the zero-extended immediate at up to STEP bits per cycle, in logical, arithmetic or rotate mode, and signals completion with a one-cycle done pulse. It sits between the instruction register and the result register and is sequenced by the control FSM through start/busy/done.

## Interface
- WIDTH, 16: datapath width in bits. Must be ≥ 2 and a power of 2.
- IMM_W, 12: immediate field width taken from IROut[IMM_W-1:0]. Must be less than WIDTH.
- STEP, 4: maximum shift distance per cycle. Must be a power of 2 and no greater than WIDTH.
- CLK  in  1  single clock, rising edge.
- CtrlRst_n  in  1  asynchronous, active-low reset.
- start  in  1  request strobe, sampled on a rising edge.
- IROut  in  WIDTH  instruction word. Bits IMM_W-1:0 are the shift amount and the immediate.
- ShifterIn  in  WIDTH  operand to shift.
- mode  in  2  shift mode: 00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical).
- dir  in  1  shift direction: 0 left, 1 right.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle pulse; result is valid.
- ShifterOut  out  WIDTH  shift result, registered.
- ZeroExtOut  out  WIDTH  registered value {0…, imm}.
- SignExtOut  out  WIDTH  registered value {imm[IMM_W-1] replicated, imm}.

## Operation
- FSM states and transitions:
  - IDLE: start → capture; next state is SHIFT if n > 0, else DONE.
  - SHIFT: shift by s = min(STEP, rem); rem -= s; when rem reaches 0 → DONE.
  - DONE: done = 1; start → capture as in IDLE; otherwise → IDLE.
- Capture on start in IDLE or DONE:
  - Latch operand, mode and dir.
  - Latch ZeroExtOut and SignExtOut from IROut[IMM_W-1:0].
  - Compute amt = zero-extended imm.
  - Load ShifterOut with ShifterIn as the working register.
- Effective amount eff:
  - Logical and arithmetic modes: eff = min(amt, WIDTH), clamped.
  - Rotate mode: eff = amt mod WIDTH.
- Cycle count: rem initialised to eff; n = ceil(eff/STEP).
- Fill rules for each step:
  - Logical: zeros shift in.
  - Arithmetic right: the MSB is replicated.
  - Arithmetic left: identical to logical left.
  - Rotate: bits wrap around.
- Boundary results:
  - Clamped shift by WIDTH gives all zeros, or all copies of the sign bit for arithmetic right.
  - eff = 0 leaves the result equal to ShifterIn.
- start while in SHIFT is ignored; it is neither queued nor does it restart the operation.
- ShifterOut and both extension outputs hold their values from DONE until the next capture.
- Reset (asynchronous, any state including mid-SHIFT):
  - State returns to IDLE and rem is cleared.
  - busy, done, ShifterOut, ZeroExtOut and SignExtOut all go to 0.
  - No done pulse is generated for the aborted operation.

## Timing
- start high in cycle c (IDLE or DONE) → done high in cycle c+1+n, for exactly one cycle.
- busy is high in cycles c+1 … c+n; it is never high together with done.
- ZeroExtOut and SignExtOut are valid from cycle c+1.
- ShifterOut is final in the done cycle; intermediate values are visible during SHIFT and are not meaningful.
- Back-to-back: start asserted in the done cycle begins the next operation with no idle bubble.
- Worst-case latency is 1 + WIDTH/STEP cycles, independent of IMM_W.

## Structure
- Shared package holds the mode encodings (SHM_LOGICAL, SHM_ARITH, SHM_ROTATE) and the FSM state encoding (IDLE/SHIFT/DONE). The control FSM uses the mode encodings too.
- Sub-module shift_step: combinational single-step shifter (WIDTH, STEP) with inputs in, s (0…STEP), mode and dir.
- The top level instantiates one shift_step and holds the FSM, rem counter, clamp/modulo logic and output registers.

## Test plan
All scenarios use WIDTH=16, IMM_W=12, STEP=4.
- Logical left, ShifterIn=0x0001, IROut=0x0005 → ShifterOut=0x0020; done at c+3; busy at c+1 and c+2.
- Arithmetic right, ShifterIn=0x8000, amt 15 → 0xFFFF; done at c+5.
- Rotate left, ShifterIn=0x1234, amt 20 (eff 4) → 0x2341; done at c+2.
- Logical right, ShifterIn=0xFFFF, IROut=0x0800 (amt 2048, clamped to 16) → 0x0000, ZeroExtOut=0x0800, SignExtOut=0xF800; done at c+5.
- Zero amount, any mode, ShifterIn=0xA5A5, amt 0 → 0xA5A5; done at c+1; busy never high.
- Interruptions:
  - start pulsed during SHIFT → ignored; the original result is produced with its original done cycle.
  - CtrlRst_n low mid-SHIFT → all outputs 0 immediately and no done pulse.
  - A later start after reset completes normally.
